neuron_mac_sequencer: RTL and testbench

Time-multiplexed controller for one 8-input neuron: accepts the input vector one element per beat, multiplies it against a programmable weight bank with a single 32-bit multiplier, accumulates, adds the bias, and presents `y = Σ x[i]*w[i] + b` on a valid/ready output. It replaces the fully parallel eight-multiplier neuron in the RNN accelerator datapath, so neuron arrays can share one MAC per neuron. Weights and bias are loaded at runtime through a write port instead of fixed parameters.

---
 rtl/neuron_mac_sequencer.sv | 114 +++++++++++
 tb/tb_neuron_mac_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_sequencer.sv
// Time-multiplexed 8-input neuron: one multiply-accumulate per accepted beat, bias add, valid/ready out.
// Define NEURON_SEQ_RELU_EN to apply ReLU to the result in the bias stage.
module neuron_mac_sequencer #(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             w_wr_en,
  input  logic [4:0]       w_wr_addr,
  input  logic [WIDTH-1:0] w_wr_data,
  output logic             w_wr_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam int unsigned IdxW = $clog2(N_INPUTS);

  typedef enum logic [1:0] {StAccum, StBias, StOut} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] bias_q, bias_d;
  logic [WIDTH-1:0] w_q [N_INPUTS];
  logic [WIDTH-1:0] w_d [N_INPUTS];
  logic             err_q, err_d;

  logic             beat, last_beat, wr_ok;
  logic [WIDTH-1:0] prod, sum;

  assign beat      = in_valid & in_ready;
  assign last_beat = beat & (idx_q == IdxW'(N_INPUTS - 1));
  assign prod      = in_data * w_q[idx_q];
  assign sum       = acc_q + bias_q;
  assign wr_ok     = w_wr_en & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
      idx_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      bias_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(N_INPUTS); i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      bias_q  <= bias_d;
      err_q   <= err_d;
      for (int i = 0; i < int'(N_INPUTS); i++) w_q[i] <= w_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (last_beat) state_d = StBias;
      StBias:  state_d = StOut;
      StOut:   if (out_ready) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    acc_d  = acc_q;
    y_d    = y_q;
    bias_d = bias_q;
    w_d    = w_q;
    err_d  = w_wr_en & busy;

    // The first beat of a vector starts from zero rather than the stale accumulator.
    if (beat) begin
      acc_d = ((idx_q == '0) ? '0 : acc_q) + prod;
      idx_d = idx_q + IdxW'(1);
    end

    if (state_q == StBias) begin
      idx_d = '0;
`ifdef NEURON_SEQ_RELU_EN
      y_d = sum[WIDTH-1] ? '0 : sum;
`else
      y_d = sum;
`endif
    end

    if (wr_ok) begin
      if (w_wr_addr < 5'(N_INPUTS)) begin
        w_d[w_wr_addr[IdxW-1:0]] = w_wr_data;
      end else if (w_wr_addr == 5'd31) begin
        bias_d = w_wr_data;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == StAccum) & ~rst;
    out_valid = (state_q == StOut);
    busy      = (idx_q != '0) | (state_q != StAccum);
    w_wr_err  = err_q;
    y         = y_q;
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer; expected results queued by stimulus, checked by a monitor.
module tb_neuron_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        w_wr_en;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic        w_wr_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;

  neuron_mac_sequencer #(.N_INPUTS(8), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .w_wr_err  (w_wr_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          t;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wv[8];
  logic [31:0] xv[8];
  int          last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops on every output handshake, checks hold behaviour under backpressure.
  logic        hs_prev = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] y_hold;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hs_prev   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (hs_prev) check("out_valid_one_cycle", {31'b0, out_valid}, 32'd0);
      hs_prev = 1'b0;
      if (out_valid) begin
        if (hold_prev) begin
          check("y_stable", y, y_hold);
          check("in_ready_in_out", {31'b0, in_ready}, 32'd0);
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=0x%08h required=none", y);
          end else begin
            e = sb.pop_front();
            check("y", y, e.val);
            if (e.t >= 0) check("latency", cyc, e.t);
          end
          hs_prev   = 1'b1;
          hold_prev = 1'b0;
        end else begin
          hold_prev = 1'b1;
          y_hold    = y;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    w_wr_en   = 1'b1;
    w_wr_addr = addr;
    w_wr_data = data;
    tick();
    w_wr_en   = 1'b0;
  endtask

  task automatic load(input logic [31:0] b);
    wait_idle();
    for (int i = 0; i < 8; i++) wr(5'(i), wv[i]);
    wr(5'd31, b);
  endtask

  task automatic send(input int lo, input int hi, input bit gap, output int lst);
    lst = -1;
    for (int i = lo; i <= hi; i++) begin
      int n = 0;
      in_valid = 1'b1;
      in_data  = xv[i];
      while (!in_ready && n < 200) begin
        tick();
        n++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL beat_accept actual=in_ready_low required=accepted");
      end
      lst = cyc;
      tick();
      in_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic expect_y(input logic [31:0] v, input int t);
    exp_t e;
    e.val = v;
    e.t   = t;
    sb.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; w_wr_en = 1'b0;
    w_wr_addr = '0; w_wr_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_during_rst", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_w_wr_err", {31'b0, w_wr_err}, 32'd0);
    check("rst_y", y, 32'd0);
    tick();

    // Basic result: 1+..+8 + 10 = 46
    for (int i = 0; i < 8; i++) begin wv[i] = 32'd1; xv[i] = 32'(i + 1); end
    load(32'd10);
    send(0, 7, 1'b0, last);
    expect_y(32'd46, last + 2);

    // Gapped weighted sum: 5*2 + 7*3 = 31
    for (int i = 0; i < 8; i++) begin wv[i] = 32'd0; xv[i] = 32'd9; end
    wv[0] = 32'd2; wv[7] = 32'd3; xv[0] = 32'd5; xv[7] = 32'd7;
    load(32'd0);
    send(0, 7, 1'b1, last);
    expect_y(32'd31, last + 2);

    // Backpressure: 1*2 + 8*3 = 26, held 5 cycles
    wait_idle();
    for (int i = 0; i < 8; i++) xv[i] = 32'(i + 1);
    out_ready = 1'b0;
    send(0, 7, 1'b0, last);
    expect_y(32'd26, -1);
    repeat (5) tick();
    out_ready = 1'b1;
    tick();
    check("in_ready_after_release", {31'b0, in_ready}, 32'd1);
    send(0, 7, 1'b0, last);
    expect_y(32'd26, last + 2);

    // Write while busy is dropped: 10+20+30+1+2+3+4+5 = 75
    for (int i = 0; i < 8; i++) wv[i] = 32'd1;
    load(32'd0);
    xv[0] = 32'd10; xv[1] = 32'd20; xv[2] = 32'd30;
    for (int i = 3; i < 8; i++) xv[i] = 32'(i - 2);
    send(0, 2, 1'b0, last);
    wr(5'd0, 32'd100);
    check("w_wr_err_pulse", {31'b0, w_wr_err}, 32'd1);
    tick();
    check("w_wr_err_clear", {31'b0, w_wr_err}, 32'd0);
    send(3, 7, 1'b0, last);
    expect_y(32'd75, last + 2);
    wait_idle();
    wr(5'd0, 32'd100);
    check("w_wr_err_idle", {31'b0, w_wr_err}, 32'd0);
    for (int i = 0; i < 8; i++) xv[i] = 32'd0;
    xv[0] = 32'd1;
    send(0, 7, 1'b0, last);
    expect_y(32'd100, last + 2);

    // Reset mid-vector: no output, weights and bias cleared
    wait_idle();
    for (int i = 0; i < 8; i++) xv[i] = 32'd1;
    send(0, 3, 1'b0, last);
    rst = 1'b1;
    tick();
    check("in_ready_mid_rst", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_no_out", {31'b0, out_valid}, 32'd0);
    end
    send(0, 7, 1'b0, last);
    expect_y(32'd0, last + 2);
    for (int i = 0; i < 8; i++) wv[i] = 32'(i + 1);
    load(32'd5);
    send(0, 7, 1'b0, last);
    expect_y(32'd41, last + 2);

    // Wrap and sign
    for (int i = 0; i < 8; i++) begin wv[i] = 32'd1; xv[i] = 32'd0; end
    xv[0] = 32'h7FFF_FFFF; xv[1] = 32'd1;
    load(32'd0);
    send(0, 7, 1'b0, last);
`ifdef NEURON_SEQ_RELU_EN
    expect_y(32'd0, last + 2);
`else
    expect_y(32'h8000_0000, last + 2);
`endif

    wait_idle();
    repeat (3) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
